cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the ALU result path and the load/store result path.
- Buffers each producer's results in a small per-source FIFO, picks one result per cycle by round-robin, and drives one registered broadcast to the reorder buffer and the reservation stations.
- Exports an almost-full flag per source so the issuing stations throttle before the buffer overflows.
- Flushes everything on ROB roll-back.

Parameters:
- DATA_W, 32, result value width
- ROB_ID_W, 4, ROB tag width
- FIFO_DEPTH, 4, entries per source FIFO (power of 2, >= 2)
- SLACK, 2, free entries still reserved when almost-full asserts (covers in-flight results)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = freeze all state, ignore inputs
- roll_back  in  1  ROB misprediction flush
- alu_valid  in  1  ALU result present this cycle
- alu_rob_id  in  ROB_ID_W  ALU result tag
- alu_value  in  DATA_W  ALU result
- lsb_valid  in  1  LSB result present this cycle
- lsb_rob_id  in  ROB_ID_W  LSB result tag
- lsb_value  in  DATA_W  LSB result
- alu_almost_full  out  1  combinational; alu_count >= FIFO_DEPTH-SLACK
- lsb_almost_full  out  1  combinational; lsb_count >= FIFO_DEPTH-SLACK
- cdb_valid  out  1  broadcast valid (registered)
- cdb_rob_id  out  ROB_ID_W  broadcast tag (registered)
- cdb_value  out  DATA_W  broadcast value (registered)
- cdb_src  out  1  0 = ALU, 1 = LSB (registered)
- overflow  out  1  sticky; set when a push hits a full FIFO

Behaviour:
- Reset (rst high at posedge):
  - both FIFOs empty, counts 0;
  - cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0, overflow=0;
  - last_grant=1 (LSB), so ALU wins the first tie.
  - rst has priority over every other input.
- roll_back high (rdy don't-care):
  - FIFOs emptied, cdb_valid<=0, last_grant unchanged, overflow unchanged;
  - inputs in that cycle are discarded.
- rdy low: all registers hold, including the cdb_* outputs. Inputs are ignored.
- Push:
  - alu_valid high pushes {alu_rob_id, alu_value} into the ALU FIFO; LSB likewise into its own FIFO.
  - Both sources may push in the same cycle.
  - Push into a FIFO with count==FIFO_DEPTH drops the entry and sets overflow.
- Arbitration, per posedge with rdy high and no flush; uses pre-edge FIFO contents:
  - both non-empty: grant the source != last_grant;
  - one non-empty: grant that source;
  - none non-empty: cdb_valid<=0, cdb_rob_id, cdb_value and cdb_src hold, last_grant holds.
- Grant effect: the head of the granted FIFO is popped into cdb_* with cdb_valid<=1; last_grant<=granted source.
- Push and pop on the same FIFO in one cycle are legal; the count is unchanged.
- Ordering: FIFO order is preserved within each source. No ordering between sources.
- Latency, without bypass:
  - result presented at edge N reaches the FIFO at N and appears on the CDB after edge N+1 at the earliest (2 cycles);
  - cdb_valid is a single-cycle pulse per result.
- Pointers: ROB_ID-independent wrap-around using log2(FIFO_DEPTH) bit pointers; count is log2(FIFO_DEPTH)+1 bits.
- Throughput: 1 result/cycle total. Sustained dual-source traffic alternates ALU, LSB, ALU, ...

Optional Feature:
- CDB_BYPASS_EN defined: a source whose FIFO is empty and whose *_valid is high competes directly in the same cycle's arbitration, using the same round-robin rule. If it wins, its input is written straight to cdb_* and is not stored, giving 1-cycle latency. If it loses, it is pushed normally.
- CDB_BYPASS_EN undefined: inputs always pass through the FIFO (2-cycle minimum latency).
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle 5 cycles -> cdb_valid=0, overflow=0, both almost_full=0 throughout.
- Single ALU result, tag 3, value 0x0000_0042, at edge N -> edge N+1 shows cdb_valid=1, tag 3, value 0x42, src 0 (edge N with CDB_BYPASS_EN); next cycle cdb_valid=0.
- Same cycle: ALU (tag 1, 0x11) and LSB (tag 2, 0x22), then 3 further cycles of simultaneous pushes -> CDB order ALU1, LSB2, ALU, LSB, ... alternating; no loss; FIFO counts return to 0 after 8 broadcasts.
- ALU pushes 4 consecutive results with LSB saturating the bus by winning alternate grants -> alu_almost_full asserts when alu_count reaches 2; a 5th push with count 4 sets overflow=1, which stays 1 until rst.
- 3 queued ALU entries, roll_back pulsed for 1 cycle -> next cycle cdb_valid=0, counts 0, and no stale tag ever appears afterwards.
- rdy low for 3 cycles while cdb_valid=1 holding tag 5 -> outputs hold tag 5 with valid 1; inputs during the stall are not queued; operation resumes when rdy returns high.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs, round-robin grant, registered broadcast.
// Optional build macro CDB_BYPASS_EN: an empty source's fresh result may win the bus directly.

module CdbResultFifo #(
    parameter int ENT_W = 36,
    parameter int DEPTH = 4,
    parameter int SLACK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [ENT_W-1:0] data_i,
    output logic [ENT_W-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almostFull_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - SLACK);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doWrite;
    logic             doRead;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == FULL_CNT);
    assign almostFull_o = (count_q >= AF_CNT);
    assign head_o       = mem_q[rdPtr_q];

    // A push into a full FIFO is dropped even if the head leaves in the same cycle.
    assign doWrite = push_i && !full_o && !flush_i;
    assign doRead  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doWrite) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doRead) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (doWrite && !doRead) begin
                count_d = count_q + CNT_W'(1);
            end else if (!doWrite && doRead) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ROB_ID_W   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SLACK      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                roll_back,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_value,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_value,
    output logic                alu_almost_full,
    output logic                lsb_almost_full,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_value,
    output logic                cdb_src,
    output logic                overflow
);
    localparam int ENT_W = ROB_ID_W + DATA_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    logic [ENT_W-1:0]    aluIn, lsbIn, aluHead, lsbHead, grantEntry;
    logic                aluEmpty, lsbEmpty, aluFull, lsbFull;
    logic                aluCand, lsbCand;
    logic                aluGranted, lsbGranted;
    logic                aluPop, lsbPop, aluPush, lsbPush, aluBypass, lsbBypass;
    logic                active;
    logic                grantValid;
    src_e                grantSrc;

    logic                cdbValid_q, cdbValid_d;
    logic [ROB_ID_W-1:0] cdbRobId_q, cdbRobId_d;
    logic [DATA_W-1:0]   cdbValue_q, cdbValue_d;
    src_e                cdbSrc_q, cdbSrc_d;
    src_e                lastGrant_q, lastGrant_d;
    logic                overflow_q, overflow_d;

    assign active = rdy && !roll_back;
    assign aluIn  = {alu_rob_id, alu_value};
    assign lsbIn  = {lsb_rob_id, lsb_value};

`ifdef CDB_BYPASS_EN
    assign aluCand = !aluEmpty || alu_valid;
    assign lsbCand = !lsbEmpty || lsb_valid;
`else
    assign aluCand = !aluEmpty;
    assign lsbCand = !lsbEmpty;
`endif

    // Round-robin: on a tie the source that did not win last time gets the bus.
    always_comb begin
        grantValid = 1'b0;
        grantSrc   = SRC_ALU;
        if (aluCand && lsbCand) begin
            grantValid = 1'b1;
            grantSrc   = (lastGrant_q == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end else if (aluCand) begin
            grantValid = 1'b1;
            grantSrc   = SRC_ALU;
        end else if (lsbCand) begin
            grantValid = 1'b1;
            grantSrc   = SRC_LSB;
        end
    end

    // A granted source with an empty FIFO can only be a bypassed input.
    assign aluGranted = active && grantValid && (grantSrc == SRC_ALU);
    assign lsbGranted = active && grantValid && (grantSrc == SRC_LSB);
    assign aluBypass  = aluGranted && aluEmpty;
    assign lsbBypass  = lsbGranted && lsbEmpty;
    assign aluPop     = aluGranted && !aluEmpty;
    assign lsbPop     = lsbGranted && !lsbEmpty;
    assign aluPush    = active && alu_valid && !aluBypass;
    assign lsbPush    = active && lsb_valid && !lsbBypass;

    always_comb begin
        grantEntry = aluEmpty ? aluIn : aluHead;
        if (grantSrc == SRC_LSB) begin
            grantEntry = lsbEmpty ? lsbIn : lsbHead;
        end
    end

    CdbResultFifo #(
        .ENT_W(ENT_W),
        .DEPTH(FIFO_DEPTH),
        .SLACK(SLACK)
    ) aluFifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (roll_back),
        .push_i      (aluPush),
        .pop_i       (aluPop),
        .data_i      (aluIn),
        .head_o      (aluHead),
        .empty_o     (aluEmpty),
        .full_o      (aluFull),
        .almostFull_o(alu_almost_full)
    );

    CdbResultFifo #(
        .ENT_W(ENT_W),
        .DEPTH(FIFO_DEPTH),
        .SLACK(SLACK)
    ) lsbFifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (roll_back),
        .push_i      (lsbPush),
        .pop_i       (lsbPop),
        .data_i      (lsbIn),
        .head_o      (lsbHead),
        .empty_o     (lsbEmpty),
        .full_o      (lsbFull),
        .almostFull_o(lsb_almost_full)
    );

    // Flush only kills the broadcast; tag, value, source, grant history and overflow survive it.
    always_comb begin
        cdbValid_d  = cdbValid_q;
        cdbRobId_d  = cdbRobId_q;
        cdbValue_d  = cdbValue_q;
        cdbSrc_d    = cdbSrc_q;
        lastGrant_d = lastGrant_q;
        overflow_d  = overflow_q;
        if (roll_back) begin
            cdbValid_d = 1'b0;
        end else if (rdy) begin
            cdbValid_d = grantValid;
            if (grantValid) begin
                cdbRobId_d  = grantEntry[DATA_W +: ROB_ID_W];
                cdbValue_d  = grantEntry[DATA_W-1:0];
                cdbSrc_d    = grantSrc;
                lastGrant_d = grantSrc;
            end
            if ((aluPush && aluFull) || (lsbPush && lsbFull)) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdbValid_q  <= 1'b0;
            cdbRobId_q  <= '0;
            cdbValue_q  <= '0;
            cdbSrc_q    <= SRC_ALU;
            lastGrant_q <= SRC_LSB;
            overflow_q  <= 1'b0;
        end else begin
            cdbValid_q  <= cdbValid_d;
            cdbRobId_q  <= cdbRobId_d;
            cdbValue_q  <= cdbValue_d;
            cdbSrc_q    <= cdbSrc_d;
            lastGrant_q <= lastGrant_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cdb_valid  = cdbValid_q;
    assign cdb_rob_id = cdbRobId_q;
    assign cdb_value  = cdbValue_q;
    assign cdb_src    = cdbSrc_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle vector table for timing and flags, plus a per-source
// scoreboard of accepted results that every broadcast is checked against in FIFO order.

module tb_cdb_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic        rdy;
        logic        rb;
        logic        av;
        logic [3:0]  aid;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  lid;
        logic [31:0] lval;
        logic [4:0]  exp;
        logic        drained;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] val;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, rdy, rollBack;
    logic        aluValid, lsbValid;
    logic [3:0]  aluRobId, lsbRobId;
    logic [31:0] aluValue, lsbValue;
    logic        aluAlmostFull, lsbAlmostFull;
    logic        cdbValid, cdbSrc, overflow;
    logic [3:0]  cdbRobId;
    logic [31:0] cdbValue;

    vec_t vecs[$];
    ent_t aluSb[$];
    ent_t lsbSb[$];
    ent_t lastExp;
    int   numChecks = 0;
    int   numPassed = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .roll_back      (rollBack),
        .alu_valid      (aluValid),
        .alu_rob_id     (aluRobId),
        .alu_value      (aluValue),
        .lsb_valid      (lsbValid),
        .lsb_rob_id     (lsbRobId),
        .lsb_value      (lsbValue),
        .alu_almost_full(aluAlmostFull),
        .lsb_almost_full(lsbAlmostFull),
        .cdb_valid      (cdbValid),
        .cdb_rob_id     (cdbRobId),
        .cdb_value      (cdbValue),
        .cdb_src        (cdbSrc),
        .overflow       (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp, input int row);
        numChecks++;
        if (act === exp) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL row %0d %s: got 0x%0h, expected 0x%0h", row, name, act, exp);
        end
    endtask

    // exp = {valid, src, aluAlmostFull, lsbAlmostFull, overflow} seen after the edge.
    task automatic addVec(input logic [1:0] rdyRb, input logic av, input logic [3:0] aid,
                          input logic [31:0] aval, input logic lv, input logic [3:0] lid,
                          input logic [31:0] lval, input logic [4:0] exp, input logic dr);
        vec_t v;
        v.rdy = rdyRb[1]; v.rb = rdyRb[0];
        v.av = av; v.aid = aid; v.aval = aval;
        v.lv = lv; v.lid = lid; v.lval = lval;
        v.exp = exp; v.drained = dr;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        ent_t e;
        rdy = v.rdy; rollBack = v.rb;
        aluValid = v.av; aluRobId = v.aid; aluValue = v.aval;
        lsbValid = v.lv; lsbRobId = v.lid; lsbValue = v.lval;
        // Accepted results are exactly those the spec keeps; pushes into a full FIFO are lost.
        if (v.rdy && !v.rb) begin
            if (v.av && aluSb.size() < DEPTH) begin
                e.id = v.aid; e.val = v.aval;
                aluSb.push_back(e);
            end
            if (v.lv && lsbSb.size() < DEPTH) begin
                e.id = v.lid; e.val = v.lval;
                lsbSb.push_back(e);
            end
        end
    endtask

    task automatic scoreBroadcast(input int row);
        ent_t e;
        int   pending;
        pending = cdbSrc ? lsbSb.size() : aluSb.size();
        numChecks++;
        if (pending == 0) begin
            $display("[TB] FAIL row %0d sb_pending: broadcast tag %0d src %0d, expected no broadcast",
                     row, cdbRobId, cdbSrc);
        end else begin
            numPassed++;
            if (cdbSrc) e = lsbSb.pop_front();
            else        e = aluSb.pop_front();
            lastExp = e;
            checkOutput("sb_tag", 32'(cdbRobId), 32'(e.id), row);
            checkOutput("sb_value", cdbValue, e.val, row);
        end
    endtask

    task automatic checkResetState(input int row);
        checkOutput("rst_valid", 32'(cdbValid), 32'd0, row);
        checkOutput("rst_tag", 32'(cdbRobId), 32'd0, row);
        checkOutput("rst_value", cdbValue, 32'd0, row);
        checkOutput("rst_src", 32'(cdbSrc), 32'd0, row);
        checkOutput("rst_overflow", 32'(overflow), 32'd0, row);
        checkOutput("rst_alu_af", 32'(aluAlmostFull), 32'd0, row);
        checkOutput("rst_lsb_af", 32'(lsbAlmostFull), 32'd0, row);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; rdy = 1'b1; rollBack = 1'b0;
        aluValid = 1'b0; aluRobId = '0; aluValue = '0;
        lsbValid = 1'b0; lsbRobId = '0; lsbValue = '0;

        // Idle after reset, then dual-source traffic alternating ALU first.
        for (int i = 0; i < 5; i++) addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b00000, 0);
        addVec(2'b10, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22, 5'b00000, 0);
        addVec(2'b10, 1, 4'd3, 32'h33, 1, 4'd4, 32'h44, 5'b10010, 0);
        addVec(2'b10, 1, 4'd5, 32'h55, 1, 4'd6, 32'h66, 5'b11110, 0);
        addVec(2'b10, 1, 4'd7, 32'h77, 1, 4'd8, 32'h88, 5'b10110, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11110, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b10010, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11000, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b10000, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11000, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b01000, 1);
        // Single ALU result: two-cycle latency, one-cycle pulse.
        addVec(2'b10, 1, 4'd3, 32'h42, 0, 0, 0, 5'b01000, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b10000, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b00000, 1);
        // Both sources push every cycle until the ALU FIFO fills; the 7th ALU push is dropped.
        addVec(2'b10, 1, 4'd9,  32'h109, 1, 4'd1, 32'h201, 5'b00000, 0);
        addVec(2'b10, 1, 4'd10, 32'h10a, 1, 4'd2, 32'h202, 5'b11100, 0);
        addVec(2'b10, 1, 4'd11, 32'h10b, 1, 4'd3, 32'h203, 5'b10110, 0);
        addVec(2'b10, 1, 4'd12, 32'h10c, 1, 4'd4, 32'h204, 5'b11110, 0);
        addVec(2'b10, 1, 4'd13, 32'h10d, 1, 4'd5, 32'h205, 5'b10110, 0);
        addVec(2'b10, 1, 4'd14, 32'h10e, 1, 4'd6, 32'h206, 5'b11110, 0);
        addVec(2'b10, 1, 4'd15, 32'h10f, 0, 0, 0, 5'b10111, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11111, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b10111, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11101, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b10001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b10001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b00001, 1);
        // Queue three ALU entries, then roll back with fresh inputs that must be discarded.
        addVec(2'b10, 1, 4'd1, 32'h301, 1, 4'd2, 32'h402, 5'b00001, 0);
        addVec(2'b10, 1, 4'd3, 32'h303, 1, 4'd4, 32'h404, 5'b11101, 0);
        addVec(2'b10, 1, 4'd5, 32'h305, 1, 4'd6, 32'h406, 5'b10111, 0);
        addVec(2'b10, 1, 4'd7, 32'h307, 0, 0, 0, 5'b11101, 0);
        addVec(2'b11, 1, 4'd9, 32'h309, 1, 4'd10, 32'h40a, 5'b01001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b01001, 1);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b01001, 0);
        // Stall with tag 5 on the bus; stalled inputs must not be queued.
        addVec(2'b10, 1, 4'd5, 32'h55, 0, 0, 0, 5'b01001, 0);
        addVec(2'b10, 0, 0, 0, 1, 4'd6, 32'h66, 5'b10001, 0);
        for (int i = 0; i < 3; i++) addVec(2'b00, 1, 4'd7, 32'h77, 1, 4'd8, 32'h88, 5'b10001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b11001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b01001, 1);
        // Roll-back still flushes while rdy is low.
        addVec(2'b10, 1, 4'd9, 32'h99, 0, 0, 0, 5'b01001, 0);
        addVec(2'b01, 1, 4'd10, 32'haa, 0, 0, 0, 5'b01001, 0);
        addVec(2'b10, 0, 0, 0, 0, 0, 0, 5'b01001, 1);

        repeat (2) @(posedge clk);
        #1;
        checkResetState(-1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v);
            @(posedge clk);
            #1;
            if (v.rb) begin
                aluSb.delete();
                lsbSb.delete();
            end else if (v.rdy && cdbValid) begin
                scoreBroadcast(i);
            end else if (!v.rdy && v.exp[4]) begin
                checkOutput("hold_tag", 32'(cdbRobId), 32'(lastExp.id), i);
                checkOutput("hold_value", cdbValue, lastExp.val, i);
            end
            checkOutput("valid", 32'(cdbValid), 32'(v.exp[4]), i);
            checkOutput("src", 32'(cdbSrc), 32'(v.exp[3]), i);
            checkOutput("alu_af", 32'(aluAlmostFull), 32'(v.exp[2]), i);
            checkOutput("lsb_af", 32'(lsbAlmostFull), 32'(v.exp[1]), i);
            checkOutput("overflow", 32'(overflow), 32'(v.exp[0]), i);
            if (v.drained) begin
                checkOutput("alu_pending", 32'(aluSb.size()), 32'd0, i);
                checkOutput("lsb_pending", 32'(lsbSb.size()), 32'd0, i);
            end
        end

        // Reset beats roll-back and valid inputs, and clears the sticky overflow.
        rst = 1'b1; rdy = 1'b1; rollBack = 1'b1;
        aluValid = 1'b1; aluRobId = 4'd11; aluValue = 32'h1bb;
        lsbValid = 1'b1; lsbRobId = 4'd12; lsbValue = 32'h2cc;
        @(posedge clk);
        #1;
        checkResetState(100);
        aluSb.delete();
        lsbSb.delete();
        rst = 1'b0; rollBack = 1'b0; aluValid = 1'b0; lsbValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_valid", 32'(cdbValid), 32'd0, 101);
        checkOutput("post_rst_alu_af", 32'(aluAlmostFull), 32'd0, 101);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end
endmodule
